game_stage_fsm: RTL and testbench

- Top-level game flow controller for the fighter display pipeline. Sits directly upstream of the colour mapper.
- Produces the mutually exclusive stage levels start_l, battle_l, win_l and lose_l that select which screen is drawn.
- Tracks both players' hit points from hit pulses issued by the collision logic.
- Uses Enter-key edges and vertical-sync frame ticks to sequence Start -> Battle -> Victory/Defeat -> Start.

---
 rtl/game_stage_fsm.sv | 143 ++++++++++++++
 tb/tb_game_stage_fsm.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_stage_fsm.sv
// game_stage_fsm
//   Top-level game flow controller for the fighter display pipeline.
//   Sequences START -> BATTLE -> WIN/LOSE -> START using Enter-key edges
//   and vertical-sync frame ticks. It also tracks both players' hit points.
//   The one-hot stage levels select the screen that the colour mapper draws.
//
// Ports
//   Clk         system clock
//   Reset_n     asynchronous active-low reset
//   frame_clk   VGA vertical sync, asynchronous to Clk
//   keycode     current keyboard keycode (8'h00 when idle)
//   p1_hit      one-Clk pulse: player 1 struck
//   p2_hit      one-Clk pulse: player 2 struck
//   start_l     title screen active
//   battle_l    battle screen active
//   win_l       victory screen active
//   lose_l      defeat screen active
//   p1_hp       player 1 hit points
//   p2_hp       player 2 hit points
//   frame_tick  one-Clk pulse per rising edge of frame_clk
module game_stage_fsm #(
    parameter int unsigned HP_INIT         = 10,
    parameter int unsigned HIT_DAMAGE      = 1,
    parameter int unsigned END_HOLD_FRAMES = 180,
    parameter logic [7:0]  KEY_ENTER       = 8'h28
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       p1_hit,
    input  logic       p2_hit,
    output logic       start_l,
    output logic       battle_l,
    output logic       win_l,
    output logic       lose_l,
    output logic [4:0] p1_hp,
    output logic [4:0] p2_hp,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        S_START,
        S_BATTLE,
        S_WIN,
        S_LOSE
    } state_t;

    localparam logic [4:0] HP_LOAD   = 5'(HP_INIT);
    localparam logic [5:0] DAMAGE    = 6'(HIT_DAMAGE);
    localparam logic [9:0] HOLD_LOAD = 10'(END_HOLD_FRAMES);

    state_t     state;
    state_t     state_nxt;
    logic [9:0] hold;
    logic [9:0] hold_nxt;
    logic [4:0] p1_nxt;
    logic [4:0] p2_nxt;
    logic [5:0] p1_sub;
    logic [5:0] p2_sub;
    logic       fsync1;
    logic       fsync2;
    logic       fprev;
    logic       key_prev;
    logic       is_enter;
    logic       enter_press;

    assign is_enter    = (keycode == KEY_ENTER);
    assign enter_press = is_enter & ~key_prev;

    always_comb begin
        // 6-bit subtract: bit 5 is the borrow and clamps the result at zero
        p1_sub    = {1'b0, p1_hp} - DAMAGE;
        p2_sub    = {1'b0, p2_hp} - DAMAGE;
        state_nxt = state;
        p1_nxt    = p1_hp;
        p2_nxt    = p2_hp;
        hold_nxt  = hold;
        case (state)
            S_START: begin
                if (enter_press) begin
                    state_nxt = S_BATTLE;
                    p1_nxt    = HP_LOAD;
                    p2_nxt    = HP_LOAD;
                end
            end
            S_BATTLE: begin
                if (p1_hit) p1_nxt = p1_sub[5] ? '0 : p1_sub[4:0];
                if (p2_hit) p2_nxt = p2_sub[5] ? '0 : p2_sub[4:0];
                // outcome judged on post-hit HP; a double knockout is a defeat
                if (p1_nxt == '0) begin
                    state_nxt = S_LOSE;
                    hold_nxt  = HOLD_LOAD;
                end else if (p2_nxt == '0) begin
                    state_nxt = S_WIN;
                    hold_nxt  = HOLD_LOAD;
                end
            end
            S_WIN, S_LOSE: begin
                if (hold == '0) begin
                    if (enter_press) state_nxt = S_START;
                end else if (frame_tick) begin
                    hold_nxt = hold - 10'd1;
                end
            end
            default: state_nxt = S_START;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsync1     <= 1'b1;
            fsync2     <= 1'b1;
            fprev      <= 1'b1;
            frame_tick <= 1'b0;
            key_prev   <= 1'b1;
            state      <= S_START;
            start_l    <= 1'b1;
            battle_l   <= 1'b0;
            win_l      <= 1'b0;
            lose_l     <= 1'b0;
            p1_hp      <= HP_LOAD;
            p2_hp      <= HP_LOAD;
            hold       <= '0;
        end else begin
            fsync1     <= frame_clk;
            fsync2     <= fsync1;
            fprev      <= fsync2;
            frame_tick <= fsync2 & ~fprev;
            key_prev   <= is_enter;
            state      <= state_nxt;
            // stage levels decoded from the next state so they switch on the transition edge
            start_l    <= (state_nxt == S_START);
            battle_l   <= (state_nxt == S_BATTLE);
            win_l      <= (state_nxt == S_WIN);
            lose_l     <= (state_nxt == S_LOSE);
            p1_hp      <= p1_nxt;
            p2_hp      <= p2_nxt;
            hold       <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_game_stage_fsm.sv
// tb_game_stage_fsm
//   Scoreboard bench for game_stage_fsm: each scenario task pushes the
//   expected stage/HP/tick word before driving a cycle and compares it
//   after the edge. A negedge monitor checks the stage levels are one-hot.
module tb_game_stage_fsm;

    localparam logic [3:0] ST = 4'b1000;
    localparam logic [3:0] BT = 4'b0100;
    localparam logic [3:0] WN = 4'b0010;
    localparam logic [3:0] LS = 4'b0001;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       p1_hit = 1'b0;
    logic       p2_hit = 1'b0;
    logic       start_l, battle_l, win_l, lose_l, frame_tick;
    logic [4:0] p1_hp, p2_hp;

    int total = 0;
    int bad = 0;

    typedef struct {
        string       tag;
        logic [14:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    logic [14:0] obs;
    assign obs = {start_l, battle_l, win_l, lose_l, p1_hp, p2_hp, frame_tick};

    game_stage_fsm #(
        .HP_INIT(10),
        .HIT_DAMAGE(1),
        .END_HOLD_FRAMES(3),
        .KEY_ENTER(8'h28)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .frame_clk(frame_clk),
        .keycode(keycode),
        .p1_hit(p1_hit),
        .p2_hit(p2_hit),
        .start_l(start_l),
        .battle_l(battle_l),
        .win_l(win_l),
        .lose_l(lose_l),
        .p1_hp(p1_hp),
        .p2_hp(p2_hp),
        .frame_tick(frame_tick)
    );

    always #10 Clk = ~Clk;

    always @(negedge Clk) begin
        total++;
        if ($countones({start_l, battle_l, win_l, lose_l}) != 1 ||
            ^{start_l, battle_l, win_l, lose_l} === 1'bx) begin
            bad++;
            $display("FAIL onehot: got %b want exactly one bit set",
                     {start_l, battle_l, win_l, lose_l});
        end
    end

    function automatic exp_t mk(string tag, logic [3:0] s, int a, int b, logic t);
        exp_t x;
        x.tag = tag;
        x.v   = {s, 5'(a), 5'(b), t};
        return x;
    endfunction

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        keycode = 8'h28;
        #2 Reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) Reset_n = 1'b1;
            if (i == 6) keycode = 8'h00;
            if (i == 7) keycode = 8'h28;
            sb.push_back(mk("reset_start", (i == 7) ? BT : ST, 10, 10, 1'b0));
            cycle();
            e = sb.pop_front();
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s[%0d]: got %h want %h", e.tag, i, obs, e.v);
            end
        end
    endtask

    task automatic test_win();
        keycode = 8'h00;
        for (int i = 1; i <= 15; i++) begin
            p1_hit = (i == 10) || (i >= 14);
            p2_hit = (i <= 13);
            if (i <= 9)
                sb.push_back(mk("win_p2_steps", BT, 10, 10 - i, 1'b0));
            else
                sb.push_back(mk("win_saturate", WN, 9, 0, 1'b0));
            cycle();
            e = sb.pop_front();
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s[%0d]: got %h want %h", e.tag, i, obs, e.v);
            end
        end
        p1_hit = 1'b0;
        p2_hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 7; c++) begin
                frame_clk = (c < 4);
                sb.push_back(mk("win_hold", WN, 9, 0, c == 2));
                cycle();
                e = sb.pop_front();
                total++;
                if (obs !== e.v) begin
                    bad++;
                    $display("FAIL %s[%0d.%0d]: got %h want %h", e.tag, k, c, obs, e.v);
                end
            end
        end
        keycode = 8'h28;
        sb.push_back(mk("win_exit", ST, 9, 0, 1'b0));
        cycle();
        e = sb.pop_front();
        total++;
        if (obs !== e.v) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
        end
    endtask

    task automatic test_outside_hits();
        keycode = 8'h00;
        p1_hit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                p1_hit = 1'b0;
                keycode = 8'h28;
            end
            sb.push_back((i == 3) ? mk("reload_hp", BT, 10, 10, 1'b0)
                                  : mk("start_hits", ST, 9, 0, 1'b0));
            cycle();
            e = sb.pop_front();
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s[%0d]: got %h want %h", e.tag, i, obs, e.v);
            end
        end
    endtask

    task automatic test_tie();
        keycode = 8'h00;
        p1_hit = 1'b1;
        p2_hit = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            sb.push_back((i == 10) ? mk("tie_lose", LS, 0, 0, 1'b0)
                                   : mk("tie_steps", BT, 10 - i, 10 - i, 1'b0));
            cycle();
            e = sb.pop_front();
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s[%0d]: got %h want %h", e.tag, i, obs, e.v);
            end
        end
        p1_hit = 1'b0;
        p2_hit = 1'b0;
    endtask

    task automatic test_hold();
        keycode = 8'h00;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 7; c++) begin
                frame_clk = (c < 4);
                sb.push_back(mk("hold_tick", LS, 0, 0, c == 2));
                cycle();
                e = sb.pop_front();
                total++;
                if (obs !== e.v) begin
                    bad++;
                    $display("FAIL %s[%0d.%0d]: got %h want %h", e.tag, k, c, obs, e.v);
                end
            end
            if (k == 1) begin
                // early press while one frame remains must be dropped
                for (int c = 0; c < 2; c++) begin
                    keycode = (c == 0) ? 8'h28 : 8'h00;
                    sb.push_back(mk("hold_early_enter", LS, 0, 0, 1'b0));
                    cycle();
                    e = sb.pop_front();
                    total++;
                    if (obs !== e.v) begin
                        bad++;
                        $display("FAIL %s[%0d]: got %h want %h", e.tag, c, obs, e.v);
                    end
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            keycode = (c == 1 || c == 3) ? 8'h28 : 8'h00;
            sb.push_back(mk("hold_release", (c == 0) ? LS : (c == 3) ? BT : ST,
                            (c == 3) ? 10 : 0, (c == 3) ? 10 : 0, 1'b0));
            cycle();
            e = sb.pop_front();
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s[%0d]: got %h want %h", e.tag, c, obs, e.v);
            end
        end
    endtask

    task automatic test_async_reset();
        keycode = 8'h00;
        p1_hit = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            sb.push_back(mk("pre_reset_hits", BT, 10 - i, 10, 1'b0));
            cycle();
            e = sb.pop_front();
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s[%0d]: got %h want %h", e.tag, i, obs, e.v);
            end
        end
        p1_hit = 1'b0;
        #4 Reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk("async_reset", ST, 10, 10, 1'b0));
            if (i == 0) #1;
            else cycle();
            if (i == 2) Reset_n = 1'b1;
            e = sb.pop_front();
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s[%0d]: got %h want %h", e.tag, i, obs, e.v);
            end
        end
        sb.push_back(mk("after_reset", ST, 10, 10, 1'b0));
        cycle();
        e = sb.pop_front();
        total++;
        if (obs !== e.v) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
        end
    endtask

    initial begin
        test_reset();
        test_win();
        test_outside_hits();
        test_tie();
        test_hold();
        test_async_reset();
        cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
